i2s_tx_sequencer: RTL and testbench
===================================

# i2s_tx_sequencer

Transmit sequencer for the APB I2S peripheral. It sits between the left/right TX FIFOs (written through TXL/TXR) and the I2S pins. It pops one stereo sample pair per frame and serializes it in Philips I2S format, with one-bit WS delay, MSB first. It is gated by CR.I2S_ENABLE and reports activity and underrun back to the register block.

## Interface
Parameters:
- DATA_W, 32: bits per channel; legal range 4..32.
- CLK_DIV, 4: pclk cycles per SCK half period; must be >= 1.

Ports:
- pclk  in  1  system/APB clock; all logic on its rising edge.
- presetn  in  1  reset, synchronous and active-low.
- i2s_enable_i  in  1  CR.I2S_ENABLE.
- fifol_empty_i  in  1  left FIFO empty.
- fifol_rdata_i  in  DATA_W  left FIFO head word; show-ahead, valid whenever not empty.
- fifol_rd_o  out  1  left FIFO pop, one pclk pulse per word.
- fifor_empty_i, fifor_rdata_i, fifor_rd_o: same as the left-FIFO ports, for the right channel.
- sck_o  out  1  I2S bit clock.
- ws_o  out  1  word select; 0 = left, 1 = right.
- sd_o  out  1  serial data.
- busy_o  out  1  sequencer not in IDLE.
- underrun_o  out  1  one-pclk pulse when a frame ends with enable=1 and either FIFO empty.

## Operation
- States: IDLE, LOAD, SHIFT, DRAIN.
- Reset: state=IDLE, sck_o=0, ws_o=0, sd_o=0, fifol_rd_o=0, fifor_rd_o=0, busy_o=0, underrun_o=0. Shift registers, slot counter, divider and the saved right LSB all clear to 0.
- IDLE -> LOAD: requires i2s_enable_i=1, fifol_empty_i=0 and fifor_empty_i=0. If only one FIFO holds data, stay in IDLE with no pop.
- LOAD (one pclk cycle):
  - Assert fifol_rd_o and fifor_rd_o together.
  - Capture both rdata words.
  - Go to SHIFT at slot 0.
- SHIFT: the frame is 2*DATA_W slots k=0..2W-1, one SCK period per slot.
  - Slot 0: sd = saved right LSB from the previous frame (0 on the first frame after IDLE); ws=0.
  - Slots 1..W: sd = left bits MSB..LSB. ws=0 for k<W-1, and ws=1 from k=W-1.
  - Slots W+1..2W-1: sd = right bits MSB..bit1; ws=1 for k<2W-1, and ws=0 at k=2W-1.
  - Right bit0 is saved for the next slot 0.
- End of slot 2W-1:
  - If i2s_enable_i=1 and both FIFOs are non-empty: pop both (rd pulse in the last pclk cycle of the slot) and start slot 0 of the next frame with no gap.
  - Otherwise go to DRAIN. underrun_o pulses if i2s_enable_i=1.
- DRAIN: one SCK period with ws=0 and sd = saved right LSB, then IDLE. On entry to IDLE, sck_o=0 and sd_o=0.
- Enable deassert mid-frame: the current frame and DRAIN complete normally, with no underrun and no further pops.
- Enable and FIFO flags are sampled only at frame boundaries and in IDLE.
- presetn low at any time forces the reset state on the next pclk edge. A frame in progress is abandoned with no pop.

## Timing
- SCK: low for CLK_DIV pclk, then high for CLK_DIV pclk. The first SCK low phase starts in the cycle after LOAD.
- sd_o and ws_o change only on the pclk edge that makes sck_o fall (or on entry to slot 0 from LOAD). They are stable across the SCK rising edge.
- Latency: 1 pclk from the IDLE->LOAD decision to the pops; 2 pclk from decision to slot 0 on the pins.
- Frame length: exactly 2*DATA_W*2*CLK_DIV pclk. Back-to-back frames have zero idle SCK periods.
- Each rd_o pulse is exactly 1 pclk wide, and there is exactly one pulse per channel per frame.
- busy_o is high from LOAD through the last DRAIN cycle.

## Test plan
- Reset: hold presetn=0 for 3 cycles with FIFOs full and enable=1 -> all outputs 0 and no rd pulse.
- Single frame (DATA_W=8, CLK_DIV=2): L=0xA5, R=0x3C, then both FIFOs empty, enable held at 1.
  - sd per slot: 0, 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0, then DRAIN 0.
  - ws per slot: 0×7, 1×8, 0, then DRAIN 0.
  - underrun_o pulses once, and the block returns to IDLE.
- Back-to-back: two pairs queued (L=0xFF/R=0x00, then L=0x01/R=0x80) -> 32 continuous SCK periods plus DRAIN, rd pulses exactly 2 per channel, and slot 0 of frame 2 carries 0.
- Enable dropped at slot 5 with more data queued -> frame and DRAIN complete, no pop after frame 1, underrun_o stays 0.
- Only the left FIFO non-empty with enable=1 -> stays IDLE, busy_o=0, no rd pulses; filling the right FIFO then starts LOAD within 1 cycle.
- presetn pulsed low mid-frame at slot 10 -> next cycle all outputs 0, IDLE; a restart pops new words cleanly.

Source files
------------

// File: rtl/i2s_tx_sequencer.sv
// Philips I2S transmit sequencer: pops one stereo pair per frame from the TX FIFOs
// and shifts it out MSB first with the one-bit WS delay.
module i2s_tx_sequencer #(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 4
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              i2s_enable_i,
    input  logic              fifol_empty_i,
    input  logic [DATA_W-1:0] fifol_rdata_i,
    output logic              fifol_rd_o,
    input  logic              fifor_empty_i,
    input  logic [DATA_W-1:0] fifor_rdata_i,
    output logic              fifor_rd_o,
    output logic              sck_o,
    output logic              ws_o,
    output logic              sd_o,
    output logic              busy_o,
    output logic              underrun_o
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SLOT_W = $clog2(2 * DATA_W);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [DIV_W-1:0]  DIV_LAST      = DIV_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST     = SLOT_W'(2 * DATA_W - 1);
    localparam logic [SLOT_W-1:0] SLOT_LEFT_END = SLOT_W'(DATA_W);
    localparam logic [SLOT_W-1:0] SLOT_WS_RISE  = SLOT_W'(DATA_W - 1);

    logic [1:0]        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              sck_q, sck_d;
    logic              ws_q, ws_d;
    logic              sd_q, sd_d;
    logic              rlsb_q, rlsb_d;
    logic              underrun_q, underrun_d;
    logic [DATA_W-1:0] shl_q, shl_d;
    logic [DATA_W-1:0] shr_q, shr_d;

    logic              phase_end;
    logic              slot_end;
    logic              last_slot;
    logic              frame_go;
    logic              start_frame;
    logic              pop;
    logic [SLOT_W-1:0] slot_nxt;

    assign phase_end = (div_q == DIV_LAST);
    assign slot_end  = phase_end && sck_q;
    assign last_slot = (slot_q == SLOT_LAST);
    assign frame_go  = i2s_enable_i && !fifol_empty_i && !fifor_empty_i;
    assign slot_nxt  = slot_q + SLOT_W'(1);

    // Pops are gated by reset so an abandoned frame never consumes a word.
    assign pop = presetn && ((state_q == ST_LOAD) ||
                             ((state_q == ST_SHIFT) && slot_end && last_slot && frame_go));

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        slot_d      = slot_q;
        sck_d       = sck_q;
        ws_d        = ws_q;
        sd_d        = sd_q;
        rlsb_d      = rlsb_q;
        underrun_d  = 1'b0;
        shl_d       = shl_q;
        shr_d       = shr_q;
        start_frame = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_go) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                start_frame = 1'b1;
            end
            ST_SHIFT, ST_DRAIN: begin
                if (phase_end) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
                if (slot_end) begin
                    if (state_q == ST_DRAIN) begin
                        state_d = ST_IDLE;
                        sck_d   = 1'b0;
                        sd_d    = 1'b0;
                        ws_d    = 1'b0;
                        rlsb_d  = 1'b0;
                        slot_d  = '0;
                    end else if (last_slot) begin
                        if (frame_go) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d    = ST_DRAIN;
                            sd_d       = rlsb_q;
                            ws_d       = 1'b0;
                            underrun_d = i2s_enable_i;
                        end
                    end else begin
                        slot_d = slot_nxt;
                        if (slot_nxt <= SLOT_LEFT_END) begin
                            sd_d  = shl_q[DATA_W-1];
                            shl_d = {shl_q[DATA_W-2:0], 1'b0};
                        end else begin
                            sd_d  = shr_q[DATA_W-1];
                            shr_d = {shr_q[DATA_W-2:0], 1'b0};
                        end
                        // WS leads the channel data by one slot.
                        ws_d = (slot_nxt >= SLOT_WS_RISE) && (slot_nxt != SLOT_LAST);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_frame) begin
            state_d = ST_SHIFT;
            slot_d  = '0;
            div_d   = '0;
            sck_d   = 1'b0;
            sd_d    = rlsb_q;
            ws_d    = 1'b0;
            shl_d   = fifol_rdata_i;
            shr_d   = fifor_rdata_i;
            rlsb_d  = fifor_rdata_i[0];
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            slot_q     <= '0;
            sck_q      <= 1'b0;
            ws_q       <= 1'b0;
            sd_q       <= 1'b0;
            rlsb_q     <= 1'b0;
            underrun_q <= 1'b0;
            shl_q      <= '0;
            shr_q      <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            slot_q     <= slot_d;
            sck_q      <= sck_d;
            ws_q       <= ws_d;
            sd_q       <= sd_d;
            rlsb_q     <= rlsb_d;
            underrun_q <= underrun_d;
            shl_q      <= shl_d;
            shr_q      <= shr_d;
        end
    end

    assign fifol_rd_o = pop;
    assign fifor_rd_o = pop;
    assign sck_o      = sck_q;
    assign ws_o       = ws_q;
    assign sd_o       = sd_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Directed bench for i2s_tx_sequencer: FIFO model plus a per-slot {ws,sd} scoreboard
// sampled at each SCK rising edge.
module tb_i2s_tx_sequencer;

    localparam int W = 8;
    localparam int D = 2;

    logic         pclk = 1'b0;
    logic         presetn;
    logic         en;
    logic         fl_empty, fr_empty;
    logic [W-1:0] fl_data, fr_data;
    logic         fifol_rd_o, fifor_rd_o;
    logic         sck_o, ws_o, sd_o, busy_o, underrun_o;

    always #5 pclk = ~pclk;

    i2s_tx_sequencer #(.DATA_W(W), .CLK_DIV(D)) dut (
        .pclk          (pclk),
        .presetn       (presetn),
        .i2s_enable_i  (en),
        .fifol_empty_i (fl_empty),
        .fifol_rdata_i (fl_data),
        .fifol_rd_o    (fifol_rd_o),
        .fifor_empty_i (fr_empty),
        .fifor_rdata_i (fr_data),
        .fifor_rd_o    (fifor_rd_o),
        .sck_o         (sck_o),
        .ws_o          (ws_o),
        .sd_o          (sd_o),
        .busy_o        (busy_o),
        .underrun_o    (underrun_o)
    );

    logic [W-1:0] lq[$];
    logic [W-1:0] rq[$];
    logic [1:0]   exp_q[$];
    logic         exp_rlsb;

    int checks   = 0;
    int failures = 0;
    int rdl_cnt, rdr_cnt, und_cnt, busy_cnt, rise_cnt;
    logic sck_prev, rdl_seen, rdr_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic upd_fifo();
        fl_empty = (lq.size() == 0);
        fr_empty = (rq.size() == 0);
        fl_data  = (lq.size() != 0) ? lq[0] : '0;
        fr_data  = (rq.size() != 0) ? rq[0] : '0;
    endtask

    task automatic clear_counts();
        rdl_cnt  = 0;
        rdr_cnt  = 0;
        und_cnt  = 0;
        busy_cnt = 0;
        rise_cnt = 0;
    endtask

    // Expected frame: slot 0 carries the previous right LSB, WS leads by one slot.
    task automatic push_frame(input logic [W-1:0] l, input logic [W-1:0] r);
        exp_q.push_back({1'b0, exp_rlsb});
        for (int j = 1; j <= W; j++) begin
            exp_q.push_back({(j >= W - 1) ? 1'b1 : 1'b0, l[W-j]});
        end
        for (int j = W + 1; j <= 2 * W - 1; j++) begin
            exp_q.push_back({(j <= 2 * W - 2) ? 1'b1 : 1'b0, r[2*W-j]});
        end
        exp_rlsb = r[0];
    endtask

    task automatic push_drain();
        exp_q.push_back({1'b0, exp_rlsb});
        exp_rlsb = 1'b0;
    endtask

    task automatic queue_pair(input logic [W-1:0] l, input logic [W-1:0] r, input bit with_exp);
        lq.push_back(l);
        rq.push_back(r);
        upd_fifo();
        if (with_exp) push_frame(l, r);
    endtask

    task automatic tick();
        logic [W-1:0] tmp;
        logic [1:0]   e;
        @(posedge pclk);
        #1;
        if (rdl_seen && lq.size() != 0) tmp = lq.pop_front();
        if (rdr_seen && rq.size() != 0) tmp = rq.pop_front();
        upd_fifo();
        @(negedge pclk);
        rdl_seen = fifol_rd_o;
        rdr_seen = fifor_rd_o;
        if (fifol_rd_o) rdl_cnt++;
        if (fifor_rd_o) rdr_cnt++;
        if (underrun_o) und_cnt++;
        if (busy_o) busy_cnt++;
        if (sck_o && !sck_prev) begin
            rise_cnt++;
            if (exp_q.size() == 0) begin
                chk("slot_queue_len", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("slot_ws_sd", {ws_o, sd_o}, e);
            end
        end
        sck_prev = sck_o;
    endtask

    task automatic run_until_idle(input int bound);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((busy_o || exp_q.size() != 0) && n < bound);
        chk("idle_timeout", (n < bound) ? 1 : 0, 1);
    endtask

    task automatic wait_rise(input int target, input int bound);
        int n = 0;
        while (rise_cnt < target && n < bound) begin
            tick();
            n++;
        end
        chk("rise_timeout", (rise_cnt >= target) ? 1 : 0, 1);
    endtask

    initial begin
        presetn  = 1'b0;
        en       = 1'b1;
        exp_rlsb = 1'b0;
        sck_prev = 1'b0;
        rdl_seen = 1'b0;
        rdr_seen = 1'b0;
        clear_counts();
        upd_fifo();

        // Reset held with data present and enable high.
        queue_pair(8'hA5, 8'h3C, 1'b1);
        push_drain();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_outputs", {sck_o, ws_o, sd_o, fifol_rd_o, fifor_rd_o, busy_o, underrun_o}, 0);
        end
        chk("reset_no_pop", lq.size(), 1);
        $display("step reset: checks=%0d", checks);

        // Single frame, then underrun.
        presetn = 1'b1;
        clear_counts();
        tick();
        chk("load_latency", {fifol_rd_o, fifor_rd_o, busy_o}, 3'b111);
        run_until_idle(400);
        chk("single_rd_l", rdl_cnt, 1);
        chk("single_rd_r", rdr_cnt, 1);
        chk("single_underrun", und_cnt, 1);
        chk("single_busy_cycles", busy_cnt, 1 + 2 * W * 2 * D + 2 * D);
        chk("single_exp_left", exp_q.size(), 0);
        chk("single_idle_pins", {sck_o, ws_o, sd_o}, 0);
        $display("step single frame L=a5 R=3c: checks=%0d", checks);

        // Back-to-back frames.
        clear_counts();
        queue_pair(8'hFF, 8'h00, 1'b1);
        queue_pair(8'h01, 8'h80, 1'b1);
        push_drain();
        run_until_idle(600);
        chk("b2b_rd_l", rdl_cnt, 2);
        chk("b2b_rd_r", rdr_cnt, 2);
        chk("b2b_sck_periods", rise_cnt, 4 * W + 1);
        chk("b2b_busy_cycles", busy_cnt, 1 + 2 * (2 * W * 2 * D) + 2 * D);
        chk("b2b_underrun", und_cnt, 1);
        chk("b2b_exp_left", exp_q.size(), 0);
        $display("step back-to-back ff/00 01/80: checks=%0d", checks);

        // Enable dropped mid-frame with a second pair waiting.
        clear_counts();
        queue_pair(8'h5A, 8'hC3, 1'b1);
        queue_pair(8'h11, 8'h22, 1'b0);
        push_drain();
        wait_rise(6, 200);
        en = 1'b0;
        run_until_idle(400);
        chk("endrop_rd_l", rdl_cnt, 1);
        chk("endrop_rd_r", rdr_cnt, 1);
        chk("endrop_underrun", und_cnt, 0);
        chk("endrop_fifo_left", lq.size(), 1);
        chk("endrop_busy_cycles", busy_cnt, 1 + 2 * W * 2 * D + 2 * D);
        chk("endrop_exp_left", exp_q.size(), 0);
        $display("step enable drop at slot 5: checks=%0d", checks);
        lq.delete();
        rq.delete();
        upd_fifo();

        // Only the left FIFO holds data.
        clear_counts();
        en = 1'b1;
        lq.push_back(8'h96);
        upd_fifo();
        for (int i = 0; i < 10; i++) tick();
        chk("oneside_busy", busy_cnt, 0);
        chk("oneside_rd", rdl_cnt + rdr_cnt, 0);
        rq.push_back(8'h69);
        upd_fifo();
        push_frame(8'h96, 8'h69);
        push_drain();
        tick();
        chk("oneside_load", {fifol_rd_o, fifor_rd_o, busy_o}, 3'b111);
        run_until_idle(400);
        chk("oneside_rd_total", rdl_cnt + rdr_cnt, 2);
        chk("oneside_underrun", und_cnt, 1);
        chk("oneside_exp_left", exp_q.size(), 0);
        $display("step left-only then right fill: checks=%0d", checks);

        // Reset mid-frame, then a clean restart.
        clear_counts();
        queue_pair(8'hC5, 8'h5C, 1'b1);
        push_drain();
        wait_rise(11, 300);
        presetn = 1'b0;
        exp_q.delete();
        exp_rlsb = 1'b0;
        tick();
        chk("midreset_outputs", {sck_o, ws_o, sd_o, fifol_rd_o, fifor_rd_o, busy_o, underrun_o}, 0);
        chk("midreset_pops", rdl_cnt, 1);
        presetn = 1'b1;
        queue_pair(8'hE7, 8'h7E, 1'b1);
        push_drain();
        run_until_idle(400);
        chk("restart_rd_l", rdl_cnt, 2);
        chk("restart_rd_r", rdr_cnt, 2);
        chk("restart_underrun", und_cnt, 1);
        chk("restart_exp_left", exp_q.size(), 0);
        $display("step reset at slot 10 and restart: checks=%0d", checks);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
